mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter onto a shared, region-decoded memory bus
//
// Purpose: grants one of two requesters (port 0 = CPU, port 1 = poller) access
// to a shared bus. It decodes the address into a one-hot region select, runs one
// bus strobe, waits RD_LAT cycles for read data and returns a done pulse with
// rdata/err.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   req0/req1             access request (hold with fields until gnt)
//   we0/we1               1 = write, 0 = read
//   addr0/addr1           request address
//   wdata0/wdata1         write data
//   gnt0/gnt1             one-cycle grant pulse (request fields latched)
//   done0/done1           one-cycle completion pulse
//   rdata, err            read result / unmapped flag, held until next completion
//   bus_en, bus_we        shared bus strobe and direction
//   bus_addr, bus_data    latched address and write data
//   bus_sel               one-hot region: RAM, button, keypad, morse, wires, extras
//   bus_q                 shared read data, valid RD_LAT cycles after bus_en
module mem_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  done0,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic                  bus_en,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_data,
  output logic [5:0]            bus_sel,
  input  logic [DATA_WIDTH-1:0] bus_q
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [ADDR_WIDTH-1:0] RAM_END    = ADDR_WIDTH'(16'hBFFF);
  localparam logic [ADDR_WIDTH-1:0] BUTTON_END = ADDR_WIDTH'(16'hCCCB);
  localparam logic [ADDR_WIDTH-1:0] KEYPAD_END = ADDR_WIDTH'(16'hD997);
  localparam logic [ADDR_WIDTH-1:0] MORSE_END  = ADDR_WIDTH'(16'hE663);
  localparam logic [ADDR_WIDTH-1:0] WIRES_END  = ADDR_WIDTH'(16'hF32F);
  localparam logic [ADDR_WIDTH-1:0] EXTRAS_END = ADDR_WIDTH'(16'hFFFB);
  localparam logic [2:0]            WAIT_LOAD  = 3'(RD_LAT - 1);

  // Regions are contiguous and ascending, so an ordered compare chain suffices.
  function automatic logic [5:0] decode(input logic [ADDR_WIDTH-1:0] a);
    if (a <= RAM_END)         return 6'b000001;
    else if (a <= BUTTON_END) return 6'b000010;
    else if (a <= KEYPAD_END) return 6'b000100;
    else if (a <= MORSE_END)  return 6'b001000;
    else if (a <= WIRES_END)  return 6'b010000;
    else if (a <= EXTRAS_END) return 6'b100000;
    else                      return 6'b000000;
  endfunction

  state_t                  state, state_nx;
  logic [2:0]              cnt, cnt_nx;
  logic                    last_gnt, last_gnt_nx;   // 1 = port 1 granted last
  logic                    port_q, port_nx;
  logic                    we_q, we_nx;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_nx;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_nx;
  logic                    gnt0_nx, gnt1_nx, done0_nx, done1_nx;
  logic                    bus_en_nx, bus_we_nx, err_nx;
  logic [5:0]              bus_sel_nx;
  logic [ADDR_WIDTH-1:0]   bus_addr_nx;
  logic [DATA_WIDTH-1:0]   bus_data_nx, rdata_nx;
  logic [5:0]              sel_q;
  logic                    pick1;

  assign sel_q = decode(addr_q);

  // Port 1 wins when alone, or on a tie when port 0 was granted last.
  assign pick1 = req1 && (!req0 || !last_gnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      last_gnt <= 1'b1;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      bus_en   <= 1'b0;
      bus_we   <= 1'b0;
      bus_sel  <= '0;
      bus_addr <= '0;
      bus_data <= '0;
      rdata    <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      last_gnt <= last_gnt_nx;
      port_q   <= port_nx;
      we_q     <= we_nx;
      addr_q   <= addr_nx;
      wdata_q  <= wdata_nx;
      gnt0     <= gnt0_nx;
      gnt1     <= gnt1_nx;
      done0    <= done0_nx;
      done1    <= done1_nx;
      bus_en   <= bus_en_nx;
      bus_we   <= bus_we_nx;
      bus_sel  <= bus_sel_nx;
      bus_addr <= bus_addr_nx;
      bus_data <= bus_data_nx;
      rdata    <= rdata_nx;
      err      <= err_nx;
    end
  end

  // Every output is registered: a state's outputs appear in the cycle after it,
  // which gives gnt at +1, bus_en at +2 and done at +3 (+RD_LAT for reads).
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    last_gnt_nx = last_gnt;
    port_nx     = port_q;
    we_nx       = we_q;
    addr_nx     = addr_q;
    wdata_nx    = wdata_q;
    gnt0_nx     = 1'b0;
    gnt1_nx     = 1'b0;
    done0_nx    = 1'b0;
    done1_nx    = 1'b0;
    bus_en_nx   = 1'b0;
    bus_we_nx   = 1'b0;
    bus_sel_nx  = '0;
    bus_addr_nx = bus_addr;
    bus_data_nx = bus_data;
    rdata_nx    = rdata;
    err_nx      = err;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          port_nx     = pick1;
          last_gnt_nx = pick1;
          we_nx       = pick1 ? we1 : we0;
          addr_nx     = pick1 ? addr1 : addr0;
          wdata_nx    = pick1 ? wdata1 : wdata0;
          gnt0_nx     = !pick1;
          gnt1_nx     = pick1;
          state_nx    = ISSUE;
        end
      end
      ISSUE: begin
        if (sel_q == 6'b000000) begin
          state_nx = RESP;
        end else begin
          bus_en_nx   = 1'b1;
          bus_we_nx   = we_q;
          bus_sel_nx  = sel_q;
          bus_addr_nx = addr_q;
          bus_data_nx = wdata_q;
          if (we_q) begin
            state_nx = RESP;
          end else begin
            cnt_nx   = WAIT_LOAD;
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 3'd0) state_nx = RESP;
        else             cnt_nx   = cnt - 3'd1;
      end
      RESP: begin
        // bus_q is valid in this cycle, exactly RD_LAT cycles after bus_en.
        // Writes, unmapped accesses and the write-only morse region read 0.
        done0_nx = !port_q;
        done1_nx = port_q;
        err_nx   = (sel_q == 6'b000000);
        rdata_nx = (we_q || sel_q == 6'b000000 || sel_q[3]) ? '0 : bus_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, err, bus_en, bus_we;
  logic [15:0] rdata, bus_addr, bus_data, bus_q;
  logic [5:0]  bus_sel;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .err(err), .bus_en(bus_en), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_data(bus_data), .bus_sel(bus_sel), .bus_q(bus_q)
  );

  // Memory model: read data appears RD_LAT (=2) cycles after bus_en, garbage otherwise.
  logic        s0_v = 1'b0, s1_v = 1'b0;
  logic [15:0] s0_a = '0, s1_a = '0;
  always @(posedge clk) begin
    s0_v <= bus_en && !bus_we;
    s0_a <= bus_addr;
    s1_v <= s0_v;
    s1_a <= s0_a;
  end
  assign bus_q = !s1_v ? 16'hDEAD : (s1_a == 16'hF330) ? 16'h00AB : (s1_a ^ 16'h5A5A);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic drop_reqs();
    req0 = 1'b0; we0 = ~we0; addr0 = ~addr0; wdata0 = ~wdata0;
    req1 = 1'b0; we1 = ~we1; addr1 = ~addr1; wdata1 = ~wdata1;
  endtask

  // One transaction from a single requester; checks latency, bus fields and result.
  task automatic txn(input string tag, input bit port, input logic we, input logic [15:0] a,
                     input logic [15:0] d, input logic [5:0] sel, input logic [15:0] rd,
                     input logic er);
    int kg, ke, kd, ne, gp, dp, lat;
    logic [5:0]  s_sel;
    logic        s_we, s_err;
    logic [15:0] s_a, s_d, s_rd;
    kg = -1; ke = -1; kd = -1; ne = 0; gp = -1; dp = -1;
    s_sel = '0; s_we = 1'b0; s_err = 1'b0; s_a = '0; s_d = '0; s_rd = '0;
    lat = (we || sel == 6'b0) ? 3 : 3 + RD_LAT;
    if (!port) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else       begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    for (int k = 1; k <= 40 && kd < 0; k++) begin
      @(negedge clk);
      check({tag, "/excl"}, 32'($countones({gnt0, gnt1, done0, done1}) <= 1), 32'd1);
      if (!bus_en) check({tag, "/bus_idle"}, {25'd0, bus_we, bus_sel}, 32'd0);
      if ((gnt0 || gnt1) && kg < 0) begin
        kg = k; gp = int'(gnt1);
        drop_reqs();
      end
      if (bus_en) begin
        ne++; ke = k; s_sel = bus_sel; s_we = bus_we; s_a = bus_addr; s_d = bus_data;
      end
      if (done0 || done1) begin
        kd = k; dp = int'(done1); s_rd = rdata; s_err = err;
      end
    end
    check({tag, "/gnt_cyc"}, kg, 32'd1);
    check({tag, "/gnt_port"}, gp, {31'd0, port});
    check({tag, "/done_cyc"}, kd, lat);
    check({tag, "/done_port"}, dp, {31'd0, port});
    check({tag, "/en_count"}, ne, (sel != 6'b0) ? 32'd1 : 32'd0);
    if (sel != 6'b0) begin
      check({tag, "/en_cyc"}, ke, 32'd2);
      check({tag, "/sel"}, {26'd0, s_sel}, {26'd0, sel});
      check({tag, "/bus_we"}, {31'd0, s_we}, {31'd0, we});
      check({tag, "/bus_addr"}, {16'd0, s_a}, {16'd0, a});
      check({tag, "/bus_data"}, {16'd0, s_d}, {16'd0, d});
    end
    check({tag, "/rdata"}, {16'd0, s_rd}, {16'd0, rd});
    check({tag, "/err"}, {31'd0, s_err}, {31'd0, er});
    @(negedge clk);
    check({tag, "/hold"}, {13'd0, done0, done1, err, rdata}, {14'd0, er, rd});
  endtask

  // Both ports request two writes at once; port 0 must go first each round.
  task automatic tie(input string tag);
    int kg0, kg1, kd0, kd1;
    logic [15:0] first_a;
    kg0 = -1; kg1 = -1; kd0 = -1; kd1 = -1; first_a = 16'hFFFF;
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0020; wdata0 = 16'h1111;
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0030; wdata1 = 16'h2222;
    for (int k = 1; k <= 40 && (kd0 < 0 || kd1 < 0); k++) begin
      @(negedge clk);
      check({tag, "/excl"}, 32'($countones({gnt0, gnt1, done0, done1}) <= 1), 32'd1);
      if (gnt0) begin kg0 = k; req0 = 1'b0; end
      if (gnt1) begin kg1 = k; req1 = 1'b0; end
      if (done0) kd0 = k;
      if (done1) kd1 = k;
      if (bus_en && first_a == 16'hFFFF) first_a = bus_addr;
    end
    check({tag, "/gnt0_cyc"}, kg0, 32'd1);
    check({tag, "/done0_cyc"}, kd0, 32'd3);
    check({tag, "/gnt1_cyc"}, kg1, 32'd4);
    check({tag, "/done1_cyc"}, kd1, 32'd6);
    check({tag, "/first_addr"}, {16'd0, first_a}, 32'h0020);
    @(negedge clk);
  endtask

  int n_done;

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (3) @(negedge clk);
    check("rst/ctl", {20'd0, gnt0, gnt1, done0, done1, bus_en, bus_we, bus_sel}, 32'd0);
    check("rst/addr_data", {bus_addr, bus_data}, 32'd0);
    check("rst/rdata_err", {15'd0, err, rdata}, 32'd0);
    reset = 1'b0;

    tie("tie1");
    tie("tie2");

    txn("wr_ram",    1'b0, 1'b1, 16'h0010, 16'h1234, 6'b000001, 16'h0000, 1'b0);
    txn("rd_extras", 1'b1, 1'b0, 16'hF330, 16'h0000, 6'b100000, 16'h00AB, 1'b0);
    txn("wr_button", 1'b1, 1'b1, 16'hC000, 16'hBEEF, 6'b000010, 16'h0000, 1'b0);
    txn("rd_unmap",  1'b0, 1'b0, 16'hFFFE, 16'h0000, 6'b000000, 16'h0000, 1'b1);
    txn("rd_ram",    1'b0, 1'b0, 16'h0100, 16'h7777, 6'b000001, 16'h5B5A, 1'b0);
    txn("rd_morse",  1'b1, 1'b0, 16'hE000, 16'h0000, 6'b001000, 16'h0000, 1'b0);
    txn("b_bfff",    1'b0, 1'b1, 16'hBFFF, 16'h0001, 6'b000001, 16'h0000, 1'b0);
    txn("b_cccb",    1'b1, 1'b1, 16'hCCCB, 16'h0002, 6'b000010, 16'h0000, 1'b0);
    txn("b_cccc",    1'b0, 1'b1, 16'hCCCC, 16'h0003, 6'b000100, 16'h0000, 1'b0);
    txn("b_d997",    1'b1, 1'b1, 16'hD997, 16'h0004, 6'b000100, 16'h0000, 1'b0);
    txn("b_d998",    1'b0, 1'b1, 16'hD998, 16'h0005, 6'b001000, 16'h0000, 1'b0);
    txn("b_e663",    1'b1, 1'b1, 16'hE663, 16'h0006, 6'b001000, 16'h0000, 1'b0);
    txn("b_e664",    1'b0, 1'b1, 16'hE664, 16'h0007, 6'b010000, 16'h0000, 1'b0);
    txn("b_f32f",    1'b1, 1'b1, 16'hF32F, 16'h0008, 6'b010000, 16'h0000, 1'b0);
    txn("b_fffb",    1'b0, 1'b1, 16'hFFFB, 16'h0009, 6'b100000, 16'h0000, 1'b0);
    txn("b_fffc",    1'b1, 1'b1, 16'hFFFC, 16'h000A, 6'b000000, 16'h0000, 1'b1);
    txn("b_ffff",    1'b0, 1'b1, 16'hFFFF, 16'h000B, 6'b000000, 16'h0000, 1'b1);
    txn("rd_keypad", 1'b0, 1'b0, 16'hD000, 16'h0000, 6'b000100, 16'h8A5A, 1'b0);

    // Reset while the read sits in WAIT: everything clears at once, no done.
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0200; wdata0 = 16'h0000;
    @(negedge clk);
    check("mid/gnt", {31'd0, gnt0}, 32'd1);
    drop_reqs();
    @(negedge clk);
    check("mid/bus_en", {31'd0, bus_en}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid/ctl", {20'd0, gnt0, gnt1, done0, done1, bus_en, bus_we, bus_sel}, 32'd0);
    check("mid/addr_data", {bus_addr, bus_data}, 32'd0);
    check("mid/rdata_err", {15'd0, err, rdata}, 32'd0);
    n_done = 0;
    repeat (2) begin
      @(negedge clk);
      if (done0 || done1) n_done++;
    end
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done0 || done1) n_done++;
    end
    check("mid/no_done", n_done, 32'd0);
    txn("post_rst",  1'b0, 1'b0, 16'h0200, 16'h0000, 6'b000001, 16'h585A, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
